seq_div8x4: RTL and testbench

- Iterative restoring divider: the inverse of the team's combinational 4x4 multiplier.
- Takes an 8-bit dividend (multiplier product width) and a 4-bit divisor; returns an 8-bit quotient and a 4-bit remainder.
- One quotient bit per clock, with a start/done handshake.
- Sits beside the multiplier in the arithmetic datapath; used to check and undo products.

---
 rtl/seq_div8x4_if.sv | 25 ++
 rtl/seq_div8x4.sv | 130 +++++++++++++
 tb/tb_seq_div8x4.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seq_div8x4_if.sv
// Start/done handshake and result bus between a requester and the seq_div8x4
// restoring divider.
interface seq_div8x4_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div8x4.sv
// Iterative restoring divider: DW-bit dividend by VW-bit divisor, one quotient
// bit per clock, with a start/done handshake and a divide-by-zero shortcut.
module seq_div8x4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_div8x4_if.slave  io_bus
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_accept;
  logic          w_zero;

  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic [VW:0]   r_part;
  logic [CW-1:0] r_count;

  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_quotient;
  logic [VW-1:0] r_remainder;
  logic          r_div_by_zero;

  logic [VW+1:0] w_diff;
  logic          w_ge;
  logic [VW:0]   w_part_nxt;
  logic [DW-1:0] w_dvd_nxt;
  logic          w_last;

  // Next-state decode; FIN accepts a new start exactly like IDLE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_zero   = (io_bus.divisor == {VW{1'b0}});
    case (r_state)
      S_IDLE, S_FIN: begin
        if (io_bus.start) begin
          w_accept = 1'b1;
          w_next   = w_zero ? S_FIN : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_count == CW'(1)) begin
          w_next = S_FIN;
        end else begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One restoring step: a borrow out of the widened subtract means partial < divisor.
  always_comb begin
    w_diff     = {r_part, r_dvd[DW-1]} - {2'b00, r_dvs};
    w_ge       = ~w_diff[VW+1];
    w_part_nxt = w_ge ? w_diff[VW:0] : {r_part[VW-1:0], r_dvd[DW-1]};
    w_dvd_nxt  = {r_dvd[DW-2:0], w_ge};
    w_last     = (r_state == S_RUN) && (r_count == CW'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath and registered outputs; the dividend register gradually fills with quotient bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd         <= {DW{1'b0}};
      r_dvs         <= {VW{1'b0}};
      r_part        <= {(VW+1){1'b0}};
      r_count       <= {CW{1'b0}};
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= {DW{1'b0}};
      r_remainder   <= {VW{1'b0}};
      r_div_by_zero <= 1'b0;
    end else begin
      r_busy <= (w_next == S_RUN);
      r_done <= (w_next == S_FIN);

      if (w_accept && !w_zero) begin
        r_dvd   <= io_bus.dividend;
        r_dvs   <= io_bus.divisor;
        r_part  <= {(VW+1){1'b0}};
        r_count <= CW'(DW);
      end else if (r_state == S_RUN) begin
        r_dvd   <= w_dvd_nxt;
        r_part  <= w_part_nxt;
        r_count <= r_count - CW'(1);
      end

      if (w_accept && w_zero) begin
        r_quotient    <= {DW{1'b1}};
        r_remainder   <= io_bus.dividend[VW-1:0];
        r_div_by_zero <= 1'b1;
      end else if (w_last) begin
        r_quotient    <= w_dvd_nxt;
        r_remainder   <= w_part_nxt[VW-1:0];
        r_div_by_zero <= 1'b0;
      end
    end
  end

  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.quotient    = r_quotient;
  assign io_bus.remainder   = r_remainder;
  assign io_bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_div8x4.sv
// Self-checking bench for seq_div8x4: directed handshake/boundary scenarios
// plus a randomized regression against a plain-arithmetic division model.
module tb_seq_div8x4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seq_div8x4_if #(.DW(8), .VW(4)) bus ();

  seq_div8x4 #(.DW(8), .VW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain division, with the fixed divide-by-zero result.
  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] q, output logic [3:0] r, output logic z);
    if (b == 4'd0) begin
      q = 8'hFF; r = a[3:0]; z = 1'b1;
    end else begin
      q = 8'(a / b); r = 4'(a % b); z = 1'b0;
    end
  endfunction

  // Issue one op from IDLE/FIN; scramble operands after acceptance; wait for done.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] q, output logic [3:0] r, output logic z,
                       output int lat, output int busy_cyc, output logic pulse_after);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = 8'($urandom); bus.divisor = 4'($urandom);
    lat = 0; busy_cyc = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
    @(posedge clk); #1;
    pulse_after = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.dividend = 8'h00; bus.divisor = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.div_by_zero});
    end
    checks++; if ({bus.quotient, bus.remainder} !== 12'h000) begin
      failures++; $display("FAIL reset_results got=%h exp=000", {bus.quotient, bus.remainder});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_inverse_mult();
    logic [7:0] q; logic [3:0] r; logic z; int lat, bc; logic pa;
    do_op(8'h8F, 4'hB, q, r, z, lat, bc, pa);
    checks++; if (q !== 8'h0D) begin failures++; $display("FAIL inv_q got=%h exp=0d", q); end
    checks++; if (r !== 4'h0) begin failures++; $display("FAIL inv_r got=%h exp=0", r); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL inv_dbz got=%b exp=0", z); end
    checks++; if (lat != 8) begin failures++; $display("FAIL inv_latency got=%0d exp=8", lat); end
    checks++; if (bc != 8) begin failures++; $display("FAIL inv_busy_cycles got=%0d exp=8", bc); end
    checks++; if (pa !== 1'b0) begin failures++; $display("FAIL inv_done_width got=%b exp=0", pa); end
  endtask

  task automatic test_extremes();
    logic [7:0] ta [4] = '{8'hFF, 8'h07, 8'hFF, 8'hFE};
    logic [3:0] tb [4] = '{4'h1, 4'h9, 4'hF, 4'hF};
    logic [7:0] tq [4] = '{8'hFF, 8'h00, 8'h11, 8'h10};
    logic [3:0] tr [4] = '{4'h0, 4'h7, 4'h0, 4'hE};
    logic [7:0] q; logic [3:0] r; logic z; int lat, bc; logic pa;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], q, r, z, lat, bc, pa);
      checks++; if ({q, r} !== {tq[i], tr[i]}) begin
        failures++; $display("FAIL extreme_%0d got=%h/%h exp=%h/%h", i, q, r, tq[i], tr[i]);
      end
      checks++; if (lat != 8) begin failures++; $display("FAIL extreme_lat_%0d got=%0d exp=8", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q; logic [3:0] r; logic z; int lat, bc; logic pa;
    do_op(8'h5A, 4'h0, q, r, z, lat, bc, pa);
    checks++; if ({q, r, z} !== {8'hFF, 4'hA, 1'b1}) begin
      failures++; $display("FAIL dbz_result got=%h/%h/%b exp=ff/a/1", q, r, z);
    end
    checks++; if (lat != 0) begin failures++; $display("FAIL dbz_latency got=%0d exp=0", lat); end
    checks++; if (pa !== 1'b0) begin failures++; $display("FAIL dbz_done_width got=%b exp=0", pa); end
    do_op(8'h10, 4'h4, q, r, z, lat, bc, pa);
    checks++; if ({q, r, z} !== {8'h04, 4'h0, 1'b0}) begin
      failures++; $display("FAIL dbz_clear got=%h/%h/%b exp=04/0/0", q, r, z);
    end
  endtask

  task automatic test_busy_ignore();
    int pulses; logic [7:0] q; logic [3:0] r;
    bus.start = 1'b1; bus.dividend = 8'hC8; bus.divisor = 4'h7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.dividend = 8'h64; bus.divisor = 4'h3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pulses = 0; q = 8'h00; r = 4'h0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) begin pulses++; q = bus.quotient; r = bus.remainder; end
      @(posedge clk); #1;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    checks++; if ({q, r} !== {8'h1C, 4'h4}) begin
      failures++; $display("FAIL ignore_result got=%h/%h exp=1c/4", q, r);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] q; logic [3:0] r;
    bus.start = 1'b1; bus.dividend = 8'h8F; bus.divisor = 4'hB;
    @(posedge clk); #1;
    bus.dividend = 8'($urandom); bus.divisor = 4'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    q = bus.quotient; r = bus.remainder;
    checks++; if ({q, r, lat[4:0]} !== {8'h0D, 4'h0, 5'd8}) begin
      failures++; $display("FAIL b2b_first got=%h/%h lat=%0d exp=0d/0 lat=8", q, r, lat);
    end
    bus.dividend = 8'hC8; bus.divisor = 4'h7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if ({bus.quotient, bus.remainder, lat[4:0]} !== {8'h1C, 4'h4, 5'd8}) begin
      failures++; $display("FAIL b2b_second got=%h/%h lat=%0d exp=1c/4 lat=8", bus.quotient, bus.remainder, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen; logic [7:0] q; logic [3:0] r; logic z; int lat, bc; logic pa;
    bus.start = 1'b1; bus.dividend = 8'hF0; bus.divisor = 4'h7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 15'h0) begin
      failures++; $display("FAIL midreset_clear got=%b%b%b/%h/%h exp=000/00/0",
        bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (bus.done === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", seen); end
    do_op(8'hF0, 4'h7, q, r, z, lat, bc, pa);
    checks++; if ({q, r, z} !== {8'h22, 4'h2, 1'b0}) begin
      failures++; $display("FAIL midreset_fresh got=%h/%h/%b exp=22/2/0", q, r, z);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, q, eq; logic [3:0] b, r, er; logic z, ez; int lat, bc; logic pa;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(1, 15));
      model(a, b, eq, er, ez);
      do_op(a, b, q, r, z, lat, bc, pa);
      checks++; if (int'(q) * int'(b) + int'(r) != int'(a) || r >= b) begin
        failures++; $display("FAIL rand_identity %h/%h got=%h r%h", a, b, q, r);
      end
      checks++; if ({q, r, z} !== {eq, er, ez}) begin
        failures++; $display("FAIL rand_model %h/%h got=%h/%h/%b exp=%h/%h/%b", a, b, q, r, z, eq, er, ez);
      end
      checks++; if (lat != 8) begin failures++; $display("FAIL rand_latency got=%0d exp=8", lat); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_inverse_mult();
    test_extremes();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
